// File: rtl/l1_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// l1_dcache_ctrl
//   Direct-mapped, write-through, no-write-allocate L1 data cache for the
//   M stage. Loads that hit return data in the same cycle. Loads that miss
//   refill the whole line one word at a time. Every store is written through
//   to memory, and a hit also updates the cached copy. While an access is
//   outstanding, `stall` holds the pipeline, including the EX/M register that
//   drives this block's request inputs.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   M_MemRead / M_MemWrite    load / store request (both set = store)
//   M_ShCtrl                  store is a halfword (sh), else a word
//   M_ALU_result              byte address of the access
//   M_Rt_data                 store data
//   cache_rdata               full load word (valid on an IDLE read hit)
//   stall                     1 = hold all pipeline registers
//   mem_req/we/addr/wdata/be  one-word request to main memory
//   mem_rdata, mem_ack        memory response, one word per ack
//   hit_cnt, miss_cnt         read hit / miss counters (wrap)
// ---------------------------------------------------------------------------
module l1_dcache_ctrl #(
  parameter int data_size   = 32,
  parameter int index_bits  = 6,
  parameter int offset_bits = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 M_MemRead,
  input  logic                 M_MemWrite,
  input  logic                 M_ShCtrl,
  input  logic [data_size-1:0] M_ALU_result,
  input  logic [data_size-1:0] M_Rt_data,
  output logic [data_size-1:0] cache_rdata,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [data_size-1:0] mem_addr,
  output logic [data_size-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic [data_size-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt
);

  localparam int lines    = 1 << index_bits;
  localparam int words    = 1 << offset_bits;
  localparam int tag_bits = data_size - 2 - offset_bits - index_bits;
  localparam logic [data_size-1:0] byte_mask = data_size'(3);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_WDONE} state_e;

  // Address split
  logic [tag_bits-1:0]    addr_tag;
  logic [index_bits-1:0]  addr_index;
  logic [offset_bits-1:0] addr_offset;
  assign addr_tag    = M_ALU_result[data_size-1 -: tag_bits];
  assign addr_index  = M_ALU_result[2+offset_bits +: index_bits];
  assign addr_offset = M_ALU_result[2 +: offset_bits];

  // State
  state_e                 state_q, state_d;
  logic [lines-1:0]       valid_q, valid_d;
  logic [offset_bits-1:0] fill_cnt_q, fill_cnt_d;
  logic                   refilled_q, refilled_d;
  logic [31:0]            hit_cnt_q, hit_cnt_d;
  logic [31:0]            miss_cnt_q, miss_cnt_d;

  // Storage
  logic [data_size-1:0] data_arr_q [lines*words];
  logic [tag_bits-1:0]  tag_arr_q  [lines];

  logic                          data_we;
  logic [index_bits+offset_bits-1:0] data_waddr;
  logic [data_size-1:0]          data_wdata;
  logic                          tag_we;

  logic                 hit;
  logic                 is_write, is_read;
  logic [data_size-1:0] cur_word;
  logic [3:0]           st_be;
  logic [data_size-1:0] st_wdata;
  logic [data_size-1:0] merged_word;

  assign hit      = valid_q[addr_index] && (tag_arr_q[addr_index] == addr_tag);
  assign is_write = M_MemWrite;
  assign is_read  = M_MemRead && !M_MemWrite;
  assign cur_word = data_arr_q[{addr_index, addr_offset}];

  // A halfword store replicates its data on both halves; the byte enables
  // pick the half named by address bit 1. The cached copy uses the same rule.
  assign st_be    = M_ShCtrl ? (M_ALU_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign st_wdata = M_ShCtrl ? {2{M_Rt_data[15:0]}} : M_Rt_data;

  always_comb begin
    merged_word = cur_word;
    for (int b = 0; b < 4; b++) begin
      if (st_be[b]) merged_word[8*b +: 8] = st_wdata[8*b +: 8];
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    valid_d     = valid_q;
    fill_cnt_d  = fill_cnt_q;
    refilled_d  = refilled_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    data_we     = 1'b0;
    data_waddr  = {addr_index, addr_offset};
    data_wdata  = merged_word;
    tag_we      = 1'b0;
    cache_rdata = '0;
    stall       = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_be      = 4'b0000;

    unique case (state_q)
      S_IDLE: begin
        // The refill marker lives for one IDLE cycle only: it exists so the
        // hit that completes a missed load is not counted as a hit.
        refilled_d = 1'b0;
        if (is_write) begin
          stall   = 1'b1;
          state_d = S_WRITE;
          data_we = hit;
        end else if (is_read) begin
          if (hit) begin
            cache_rdata = cur_word;
            if (!refilled_q) hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            stall      = 1'b1;
            state_d    = S_REFILL;
            miss_cnt_d = miss_cnt_q + 32'd1;
            fill_cnt_d = '0;
          end
        end
      end

      S_REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {addr_tag, addr_index, fill_cnt_q, 2'b00};
        if (mem_ack) begin
          data_we    = 1'b1;
          data_waddr = {addr_index, fill_cnt_q};
          data_wdata = mem_rdata;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q == {offset_bits{1'b1}}) begin
            valid_d[addr_index] = 1'b1;
            tag_we              = 1'b1;
            refilled_d          = 1'b1;
            state_d             = S_IDLE;
          end
        end
      end

      S_WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = M_ALU_result & ~byte_mask;
        mem_wdata = st_wdata;
        mem_be    = st_be;
        if (mem_ack) state_d = S_WDONE;
      end

      // One unstalled cycle lets EX/M move past the store so it is not
      // seen again in IDLE.
      S_WDONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      valid_q    <= '0;
      fill_cnt_q <= '0;
      refilled_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      fill_cnt_q <= fill_cnt_d;
      refilled_q <= refilled_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // NOTE: data and tag arrays have no reset; the valid bits alone decide
  // whether their contents mean anything, which lets them map onto RAM.
  always_ff @(posedge clk) begin
    if (data_we) data_arr_q[data_waddr] <= data_wdata;
    if (tag_we)  tag_arr_q[addr_index]  <= addr_tag;
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

endmodule
